wb_mailbox_slave: RTL and testbench

WB_MAILBOX_SLAVE -- requirements
Module: wb_mailbox_slave

---
 rtl/wb_mailbox_slave.sv | 169 ++++++++++++++++
 tb/tb_wb_mailbox_slave.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mailbox_slave.sv
// Wishbone slave exposing a register bank and a FIFO mailbox. Define
// WB_MAILBOX_IRQ_EN to build the irq_enable control bit and the not-empty interrupt.
module wb_mailbox_slave #(
  parameter int         ADDR_WIDTH = 16,
  parameter int         DATA_WIDTH = 16,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] BASE_ADDR  = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] wbs_address,
  input  logic [DATA_WIDTH-1:0] wbs_writedata,
  output logic [DATA_WIDTH-1:0] wbs_readdata,
  input  logic                  wbs_write,
  input  logic                  wbs_strobe,
  input  logic                  wbs_cycle,
  output logic                  wbs_ack,
  output logic                  irq
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] REG_ID      = 3'd0;
  localparam logic [2:0] REG_SCRATCH = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_DATA    = 3'd3;
  localparam logic [2:0] REG_CONTROL = 3'd4;

  typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

  state_t                state;
  logic [2:0]            acc_sel;
  logic                  acc_write;
  logic [DATA_WIDTH-1:0] acc_wdata;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic                  underflow;
  logic [DATA_WIDTH-1:0] scratch;

  logic                  request;
  logic                  empty;
  logic                  full;
  logic                  in_ack;
  logic                  data_wr;
  logic                  data_rd;
  logic                  status_wr;
  logic                  ctrl_wr;
  logic                  do_push;
  logic                  do_pop;
  logic                  do_clear;
  logic [15:0]           status_word;
  logic [DATA_WIDTH-1:0] rd_value;
  logic                  unused_addr;

  assign request     = wbs_cycle & wbs_strobe & (wbs_address[15:8] == BASE_ADDR);
  assign empty       = (count == '0);
  assign full        = (count == CNT_W'(FIFO_DEPTH));
  assign status_word = {9'(count), 3'b000, underflow, overflow, full, empty};
  assign unused_addr = ^wbs_address;

  // The access is latched at request time and its side effects are applied
  // on the edge that ends the ACK cycle.
  assign in_ack    = (state == ACK);
  assign data_wr   = in_ack &  acc_write & (acc_sel == REG_DATA);
  assign data_rd   = in_ack & ~acc_write & (acc_sel == REG_DATA);
  assign status_wr = in_ack &  acc_write & (acc_sel == REG_STATUS);
  assign ctrl_wr   = in_ack &  acc_write & (acc_sel == REG_CONTROL);
  assign do_push   = data_wr & ~full;
  assign do_pop    = data_rd & ~empty;
  assign do_clear  = ctrl_wr & acc_wdata[0];

`ifdef WB_MAILBOX_IRQ_EN
  logic irq_enable;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_enable <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (ctrl_wr) irq_enable <= acc_wdata[1];
      irq <= irq_enable & ~empty;
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // rd_value unassigned and infers a latch.
    rd_value = '0;
    case (wbs_address[2:0])
      REG_ID:      rd_value = DATA_WIDTH'(16'hBE57);
      REG_SCRATCH: rd_value = scratch;
      REG_STATUS:  rd_value = DATA_WIDTH'(status_word);
      REG_DATA:    if (!empty) rd_value = mem[rd_ptr];
`ifdef WB_MAILBOX_IRQ_EN
      REG_CONTROL: rd_value = DATA_WIDTH'({irq_enable, 1'b0});
`endif
      default:     rd_value = '0;
    endcase
  end

  // NOTE: the mailbox storage has no reset; only pointers and count define
  // which entries are valid, so clearing the array would be wasted logic.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr] <= acc_wdata;
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wbs_ack      <= 1'b0;
      wbs_readdata <= '0;
      acc_sel      <= '0;
      acc_write    <= 1'b0;
      acc_wdata    <= '0;
      scratch      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wbs_ack      <= 1'b0;
      wbs_readdata <= '0;

      case (state)
        IDLE: if (request) begin
          state        <= ACK;
          wbs_ack      <= 1'b1;
          wbs_readdata <= wbs_write ? '0 : rd_value;
          acc_sel      <= wbs_address[2:0];
          acc_write    <= wbs_write;
          acc_wdata    <= wbs_writedata;
        end
        ACK:  state <= HOLD;
        HOLD: if (!wbs_strobe || !wbs_cycle) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (in_ack && acc_write && acc_sel == REG_SCRATCH) scratch <= acc_wdata;

      if (data_wr && full)                 overflow <= 1'b1;
      else if (status_wr && acc_wdata[2])  overflow <= 1'b0;

      if (data_rd && empty)                underflow <= 1'b1;
      else if (status_wr && acc_wdata[3])  underflow <= 1'b0;

      if (do_clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
    end
  end

endmodule

// File: tb/tb_wb_mailbox_slave.sv
// Randomized self-checking bench for wb_mailbox_slave against a queue-based
// mailbox model; honours WB_MAILBOX_IRQ_EN when the build defines it.
module tb_wb_mailbox_slave;

  localparam int         DEPTH = 16;
  localparam logic [7:0] BASE  = 8'h00;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] wbs_address;
  logic [15:0] wbs_writedata;
  logic [15:0] wbs_readdata;
  logic        wbs_write;
  logic        wbs_strobe;
  logic        wbs_cycle;
  logic        wbs_ack;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Mailbox model
  logic [15:0] mq[$];
  logic [15:0] m_scratch;
  logic        m_over;
  logic        m_under;
  logic        m_irq_en;

  wb_mailbox_slave #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(16),
    .FIFO_DEPTH(DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wbs_address  (wbs_address),
    .wbs_writedata(wbs_writedata),
    .wbs_readdata (wbs_readdata),
    .wbs_write    (wbs_write),
    .wbs_strobe   (wbs_strobe),
    .wbs_cycle    (wbs_cycle),
    .wbs_ack      (wbs_ack),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_scratch = '0;
    m_over    = 1'b0;
    m_under   = 1'b0;
    m_irq_en  = 1'b0;
  endfunction

  function automatic logic model_irq();
    return m_irq_en && (mq.size() != 0);
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] addr);
    logic [15:0] v;
    v = '0;
    case (addr[2:0])
      3'd0: v = 16'hBE57;
      3'd1: v = m_scratch;
      3'd2: v = {9'(mq.size()), 3'b000, m_under, m_over,
                 mq.size() == DEPTH, mq.size() == 0};
      3'd3: if (mq.size() != 0) v = mq[0];
      3'd4: v = {14'b0, m_irq_en, 1'b0};
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic void model_apply(input logic [15:0] addr, input logic we,
                                      input logic [15:0] wdata);
    if (!we) begin
      if (addr[2:0] == 3'd3) begin
        if (mq.size() != 0) void'(mq.pop_front());
        else                m_under = 1'b1;
      end
    end else begin
      case (addr[2:0])
        3'd1: m_scratch = wdata;
        3'd2: begin
          if (wdata[3]) m_under = 1'b0;
          if (wdata[2]) m_over  = 1'b0;
        end
        3'd3: if (mq.size() < DEPTH) mq.push_back(wdata);
              else                   m_over = 1'b1;
        3'd4: begin
          if (wdata[0]) mq.delete();
`ifdef WB_MAILBOX_IRQ_EN
          m_irq_en = wdata[1];
`endif
        end
        default: ;
      endcase
    end
  endfunction

  // Starts just after a rising edge; holds strobe for `hold` cycles from the
  // request edge and leaves the bus idle one cycle after release.
  task automatic bus_access(input logic [15:0] addr, input logic we,
                            input logic [15:0] wdata, input int hold);
    logic [15:0] exp_rd;
    logic        hit;
    logic        irq_before;
    int          acks;
    hit        = (addr[15:8] == BASE);
    exp_rd     = model_read(addr);
    irq_before = model_irq();
    wbs_address   = addr;
    wbs_write     = we;
    wbs_writedata = wdata;
    wbs_cycle     = 1'b1;
    wbs_strobe    = 1'b1;
    @(posedge clk); #1;
    check("ack_timing", wbs_ack, hit);
    if (hit && !we) check($sformatf("rd_%0h", addr), wbs_readdata, exp_rd);
    acks = int'(wbs_ack);
    if (hit) model_apply(addr, we, wdata);
    @(posedge clk); #1;
    check("irq_lag", irq, irq_before);
    check("rd_zero_noack", wbs_readdata, 16'h0);
    acks += int'(wbs_ack);
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
      acks += int'(wbs_ack);
    end
    wbs_strobe = 1'b0;
    wbs_cycle  = 1'b0;
    @(posedge clk); #1;
    acks += int'(wbs_ack);
    check("ack_count", acks, hit ? 1 : 0);
    check("irq", irq, model_irq());
  endtask

  task automatic read_status();
    bus_access(16'h0002, 1'b0, 16'h0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;

    reset         = 1'b1;
    wbs_address   = '0;
    wbs_writedata = '0;
    wbs_write     = 1'b0;
    wbs_strobe    = 1'b0;
    wbs_cycle     = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", wbs_ack, 1'b0);
    check("reset_rdata", wbs_readdata, 16'h0);
    check("reset_irq", irq, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // ID read with strobe held for five cycles
    bus_access(16'h0000, 1'b0, 16'h0, 5);
    check("id_const", model_read(16'h0000), 16'hBE57);

    // Scratch round trip and an out-of-range base
    bus_access(16'h0001, 1'b1, 16'h1234, 1);
    bus_access(16'h0001, 1'b0, 16'h0, 2);
    bus_access(16'h0101, 1'b0, 16'h0, 3);
    bus_access(16'h0101, 1'b1, 16'hFFFF, 1);
    read_status();

    // Fill past full, then drain in order
    for (int i = 0; i < 17; i++) bus_access(16'h0003, 1'b1, 16'(i), 1);
    read_status();
    check("fill_count", mq.size(), DEPTH);
    for (int i = 0; i < 16; i++) bus_access(16'h0003, 1'b0, 16'h0, 1);
    read_status();

    // Underflow, then W1C of both error flags
    bus_access(16'h0003, 1'b0, 16'h0, 1);
    read_status();
    bus_access(16'h0002, 1'b1, 16'h000C, 1);
    read_status();

    // Clear via CONTROL, then alternate push/pop across the pointer wrap
    for (int i = 0; i < 3; i++) bus_access(16'h0003, 1'b1, 16'hA000 + 16'(i), 1);
    bus_access(16'h0004, 1'b1, 16'h0001, 1);
    read_status();
    for (int i = 0; i < 40; i++) begin
      bus_access(16'h0003, 1'b1, 16'h5A00 + 16'(i), 1);
      bus_access(16'h0003, 1'b0, 16'h0, 1);
    end
    read_status();

    // Interrupt enable, push, pop
    bus_access(16'h0004, 1'b1, 16'h0002, 1);
    bus_access(16'h0004, 1'b0, 16'h0, 1);
    bus_access(16'h0003, 1'b1, 16'hC0DE, 1);
    bus_access(16'h0003, 1'b0, 16'h0, 1);

    // Reset asserted during the ACK cycle of a push
    wbs_address   = 16'h0003;
    wbs_write     = 1'b1;
    wbs_writedata = 16'hDEAD;
    wbs_cycle     = 1'b1;
    wbs_strobe    = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ack", wbs_ack, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ack_low", wbs_ack, 1'b0);
    check("rst_mid_irq", irq, 1'b0);
    reset      = 1'b0;
    wbs_strobe = 1'b0;
    wbs_cycle  = 1'b0;
    model_reset();
    @(posedge clk); #1;
    read_status();
    bus_access(16'h0003, 1'b0, 16'h0, 1);
    bus_access(16'h0002, 1'b1, 16'h000C, 1);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      addr[15:8] = ($urandom_range(0, 15) == 0) ? 8'h01 : BASE;
      addr[7:3]  = 5'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: addr[2:0] = 3'd3;
        5:             addr[2:0] = 3'd2;
        6:             addr[2:0] = 3'd4;
        default:       addr[2:0] = 3'($urandom);
      endcase
      we    = 1'($urandom);
      wdata = 16'($urandom);
      if (addr[2:0] == 3'd4 && $urandom_range(0, 3) != 0) wdata[0] = 1'b0;
      bus_access(addr, we, wdata, int'($urandom_range(1, 3)));
    end
    read_status();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
